tokenizer: RTL

Forth outer-interpreter parse stage: scans the terminal input buffer in byte memory, skips leading whitespace, and delimits the next blank-separated word. Reports the token start address, its length and the updated parse pointer (>IN) for the dictionary search and `atoi` number-conversion stages downstream, which read the token characters from memory themselves. Memory access uses the same one-cycle read latency as those stages: address out, data valid next cycle.

---
 rtl/tokenizer.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/tokenizer.sv
// Forth parse stage: skips blanks from a0, delimits the next word, reports its start, its length and the updated >IN.
// Optional over-length detection (31-byte cap, err flag) is enabled by defining TOKENIZER_MAXLEN_EN.
module tokenizer #(
    parameter int ASZ = 17,
    parameter int LSZ = 8
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    input  logic [ASZ-1:0] a0,
    input  logic [ASZ-1:0] lim,
    output logic [ASZ-1:0] ma,
    input  logic [7:0]     mi,
    output logic           bsy,
    output logic           done,
    output logic [ASZ-1:0] tok_a,
    output logic [LSZ-1:0] tok_n,
    output logic [ASZ-1:0] nxt_a,
    output logic           eol,
    output logic           err,
    output logic [2:0]     st
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        SK_RD  = 3'd1,
        SK_CHK = 3'd2,
        SC_RD  = 3'd3,
        SC_CHK = 3'd4,
        DONE   = 3'd5
    } state_t;

`ifdef TOKENIZER_MAXLEN_EN
    localparam logic [LSZ-1:0] NMAX   = LSZ'(31);
    localparam logic           LIM_EN = 1'b1;
`else
    localparam logic [LSZ-1:0] NMAX   = {LSZ{1'b1}};
    localparam logic           LIM_EN = 1'b0;
`endif

    state_t         state, state_nx;
    logic [ASZ-1:0] ptr, ptr_nx;
    logic [ASZ-1:0] lim_r, lim_nx;
    logic [ASZ-1:0] tok_a_nx, nxt_a_nx;
    logic [LSZ-1:0] tok_n_nx;
    logic           eol_nx, err_nx;
    logic           ws;

    assign ws = (mi != 8'h00) && (mi <= 8'h20);

    always_comb begin
        state_nx = state;
        ptr_nx   = ptr;
        lim_nx   = lim_r;
        tok_a_nx = tok_a;
        tok_n_nx = tok_n;
        nxt_a_nx = nxt_a;
        eol_nx   = eol;
        err_nx   = err;
        case (state)
            IDLE: begin
                if (start) begin
                    ptr_nx   = a0;
                    // An empty or inverted window collapses to ptr==lim so the first RD ends the scan.
                    lim_nx   = (lim <= a0) ? a0 : lim;
                    tok_n_nx = '0;
                    eol_nx   = 1'b0;
                    err_nx   = 1'b0;
                    state_nx = SK_RD;
                end
            end
            SK_RD, SC_RD: begin
                if (ptr == lim_r) begin
                    eol_nx   = 1'b1;
                    nxt_a_nx = ptr;
                    state_nx = DONE;
                end else begin
                    state_nx = (state == SK_RD) ? SK_CHK : SC_CHK;
                end
            end
            SK_CHK: begin
                if (mi == 8'h00) begin
                    eol_nx   = 1'b1;
                    nxt_a_nx = ptr;
                    state_nx = DONE;
                end else if (ws) begin
                    ptr_nx   = ptr + 1'b1;
                    state_nx = SK_RD;
                end else begin
                    tok_a_nx = ptr;
                    tok_n_nx = LSZ'(1);
                    ptr_nx   = ptr + 1'b1;
                    state_nx = SC_RD;
                end
            end
            SC_CHK: begin
                if (mi == 8'h00) begin
                    eol_nx   = 1'b1;
                    nxt_a_nx = ptr;
                    state_nx = DONE;
                end else if (ws) begin
                    nxt_a_nx = ptr + 1'b1;
                    state_nx = DONE;
                end else begin
                    if (tok_n == NMAX) err_nx = err | LIM_EN;
                    else               tok_n_nx = tok_n + 1'b1;
                    ptr_nx   = ptr + 1'b1;
                    state_nx = SC_RD;
                end
            end
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            ptr   <= '0;
            lim_r <= '0;
            tok_a <= '0;
            tok_n <= '0;
            nxt_a <= '0;
            eol   <= 1'b0;
            err   <= 1'b0;
        end else begin
            state <= state_nx;
            ptr   <= ptr_nx;
            lim_r <= lim_nx;
            tok_a <= tok_a_nx;
            tok_n <= tok_n_nx;
            nxt_a <= nxt_a_nx;
            eol   <= eol_nx;
            err   <= err_nx;
        end
    end

    assign ma   = ptr;
    assign bsy  = (state != IDLE) && (state != DONE);
    assign done = (state == DONE);
    assign st   = state;

endmodule
